// File: rtl/ss_seq_if.sv
// ss_seq_if: save-state port and state buffer port between sequencer and mapper/buffer
interface ss_seq_if;
   logic       ss_act;
   logic       ss_we;
   logic [7:0] ss_addr;
   logic [7:0] ss_wdat;
   logic [7:0] ss_rdat;
   logic       mem_req;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdat;
   logic [7:0] mem_rdat;
   logic       mem_ack;
   modport master (
      output ss_act, ss_we, ss_addr, ss_wdat, mem_req, mem_we, mem_addr, mem_wdat,
      input  ss_rdat, mem_rdat, mem_ack
   );
   modport slave (
      input  ss_act, ss_we, ss_addr, ss_wdat, mem_req, mem_we, mem_addr, mem_wdat,
      output ss_rdat, mem_rdat, mem_ack
   );
endinterface

// File: rtl/ss_seq.sv
// ss_seq: dumps mapper save-state bytes to a buffer or restores them aligned to m2 falls
module ss_seq #(
   parameter int SS_LEN   = 256,
   parameter int IDX_ADDR = 127
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     m2,
   input  logic     cmd_save,
   input  logic     cmd_load,
   output logic     busy,
   output logic     done,
   output logic     err,
   ss_seq_if.master bus
);
   typedef enum logic [3:0] {
      IDLE, S_SET, S_SETTLE, S_MWR, L_CHK, L_MRD, L_PRES, L_WHI, L_WLO, L_NEXT, DONE, ERR
   } state_t;
   state_t     state, nxt;
   logic [8:0] cnt, cnt_n, cnt_inc;
   logic [7:0] wd, wd_n, md, md_n;
   logic       m2_q, last;
   assign cnt_inc = cnt + 9'd1;
   assign last    = cnt_inc == 9'(SS_LEN);
   // state register, address counter, data latches and m2 history for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         wd    <= '0;
         md    <= '0;
         m2_q  <= 1'b0;
      end else begin
         state <= nxt;
         cnt   <= cnt_n;
         wd    <= wd_n;
         md    <= md_n;
         m2_q  <= m2;
      end
   end
   // sequencing: save walks set/settle/write, load checks the index then writes per m2 period
   always_comb begin
      nxt   = state;
      cnt_n = cnt;
      wd_n  = wd;
      md_n  = md;
      case (state)
         IDLE: begin
            nxt   = cmd_save ? S_SET : (cmd_load ? L_CHK : IDLE);
            cnt_n = (cmd_save || cmd_load) ? 9'd0 : cnt;
         end
         S_SET:    nxt = S_SETTLE;
         S_SETTLE: begin
            nxt  = S_MWR;
            md_n = bus.ss_rdat;
         end
         S_MWR: begin
            nxt   = bus.mem_ack ? (last ? DONE : S_SET) : S_MWR;
            cnt_n = bus.mem_ack ? cnt_inc : cnt;
         end
         L_CHK:  nxt = bus.mem_ack ? ((bus.mem_rdat == bus.ss_rdat) ? L_MRD : ERR) : L_CHK;
         L_MRD: begin
            nxt  = bus.mem_ack ? L_PRES : L_MRD;
            wd_n = bus.mem_ack ? bus.mem_rdat : wd;
         end
         L_PRES: nxt = L_WHI;
         L_WHI:  nxt = (m2 && !m2_q) ? L_WLO : L_WHI;
         L_WLO:  nxt = (!m2 && m2_q) ? L_NEXT : L_WLO;
         L_NEXT: begin
            nxt   = last ? DONE : L_MRD;
            cnt_n = cnt_inc;
         end
         default: nxt = IDLE;
      endcase
   end
   assign busy         = !(state inside {IDLE, DONE, ERR});
   assign done         = state == DONE;
   assign err          = state == ERR;
   assign bus.ss_act   = busy;
   assign bus.ss_we    = state inside {L_PRES, L_WHI, L_WLO, L_NEXT};
   assign bus.ss_addr  = (state == L_CHK) ? 8'(IDX_ADDR) : (busy ? cnt[7:0] : 8'd0);
   assign bus.ss_wdat  = wd;
   assign bus.mem_req  = state inside {S_MWR, L_CHK, L_MRD};
   assign bus.mem_we   = state == S_MWR;
   assign bus.mem_addr = bus.ss_addr;
   assign bus.mem_wdat = md;
endmodule

// File: tb/tb_ss_seq.sv
// tb_ss_seq: mapper/buffer models plus per-cycle protocol scoreboard for ss_seq
module tb_ss_seq;
   logic clk = 1'b0;
   logic rst, m2, cmd_save, cmd_load, busy, done, err;
   ss_seq_if bus();
   ss_seq dut (
      .clk(clk), .rst(rst), .m2(m2), .cmd_save(cmd_save), .cmd_load(cmd_load),
      .busy(busy), .done(done), .err(err), .bus(bus.master)
   );
   always #5 clk = ~clk;
   int checks = 0, errors = 0;
   logic [7:0] mbuf [256];
   logic [7:0] mreg [256];
   logic [7:0] gold [256];
   logic [7:0] idx;
   int mode, op, lat_min, lat_max, one_fall;
   int nwr, nrd, nwe, ndone, nerr, busy_cyc, exp_addr, exp_we, ld_first;
   int falls, age, m2c;
   logic m2_p, we_prev;
   logic [7:0] p_addr, p_dat;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [7:0] map_rd(input logic [7:0] a);
      return (mode != 0) ? ((a == 8'd127) ? idx : mreg[a]) : (a ^ 8'h5A);
   endfunction
   assign bus.ss_rdat = map_rd(bus.ss_addr);
   initial begin
      m2 = 1'b0;
      m2c = 0;
      forever begin
         @(posedge clk);
         #2;
         m2c = (m2c + 1) % 28;
         m2 = m2c >= 14;
      end
   end
   initial begin : mem_model
      int rc, lat;
      rc = 0;
      lat = 1;
      bus.mem_ack = 1'b0;
      bus.mem_rdat = 8'd0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
            rc = 0;
         end
         if (bus.mem_req) begin
            if (rc == 0) lat = $urandom_range(lat_max, lat_min);
            rc++;
            if (rc == lat + 1) begin
               bus.mem_ack = 1'b1;
               if (bus.mem_we) mbuf[bus.mem_addr] = bus.mem_wdat;
               else bus.mem_rdat = mbuf[bus.mem_addr];
            end
         end
      end
   end
   always @(negedge clk) begin
      if (rst) begin
         we_prev = 1'b0;
         m2_p = m2;
      end else begin
         chk("busy_act", busy, bus.ss_act);
         if (done || err) chk("end_idle", {busy, bus.ss_act, bus.ss_we, bus.mem_req}, 0);
         if (bus.ss_we) chk("we_load", op, 1);
         if (bus.mem_req) begin
            chk("mem_addr", bus.mem_addr, bus.ss_addr);
            chk("mem_we", bus.mem_we, op == 0);
         end
         if (bus.mem_req && bus.mem_ack) begin
            if (op == 0) begin
               chk("save_addr", bus.mem_addr, exp_addr);
               chk("save_dat", bus.mem_wdat, map_rd(bus.mem_addr));
               exp_addr++;
               nwr++;
            end else begin
               chk("load_rd_addr", bus.mem_addr, (ld_first != 0) ? 127 : exp_addr);
               if (ld_first == 0) exp_addr++;
               ld_first = 0;
               nrd++;
            end
         end
         if (bus.ss_we) begin
            if (!we_prev) begin
               chk("we_addr", bus.ss_addr, exp_we);
               chk("we_dat", bus.ss_wdat, mbuf[bus.ss_addr]);
               p_addr = bus.ss_addr;
               p_dat = bus.ss_wdat;
               falls = 0;
               age = 0;
            end else begin
               chk("we_stable", {bus.ss_addr, bus.ss_wdat}, {p_addr, p_dat});
               age++;
            end
            if (m2_p && !m2) begin
               falls++;
               age = 0;
               mreg[bus.ss_addr] = bus.ss_wdat;
            end
         end else if (we_prev) begin
            nwe++;
            exp_we++;
            chk("we_falls", (one_fall != 0) ? falls : int'(falls > 0), 1);
            chk("we_tail", age, 1);
         end
         busy_cyc += int'(busy);
         ndone += int'(done);
         nerr += int'(err);
         m2_p = m2;
         we_prev = bus.ss_we;
      end
   end
   task automatic clear();
      nwr = 0; nrd = 0; nwe = 0; ndone = 0; nerr = 0; busy_cyc = 0;
      exp_addr = 0; exp_we = 0; ld_first = 1;
   endtask
   task automatic pulse(input logic s, input logic l);
      @(posedge clk);
      #1;
      cmd_save = s;
      cmd_load = l;
      @(posedge clk);
      #1;
      cmd_save = 1'b0;
      cmd_load = 1'b0;
   endtask
   task automatic wait_end(output logic act_end);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(done || err) && n < 20000);
      chk("end_seen", done || err, 1);
      act_end = bus.ss_act;
      @(negedge clk);
   endtask
   task automatic sync_m2();
      int n = 0;
      while (m2 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      while (m2 === 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk("m2_sync", n < 100, 1);
   endtask
   initial begin
      logic act_end;
      int bad, n;
      logic mp;
      rst = 1'b1; cmd_save = 1'b0; cmd_load = 1'b0;
      mode = 0; op = 0; lat_min = 1; lat_max = 1; one_fall = 1; idx = 8'h33;
      for (int i = 0; i < 256; i++) begin mbuf[i] = 8'd0; mreg[i] = 8'd0; end
      clear();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_outs", {busy, done, err, bus.ss_act, bus.ss_we, bus.ss_addr, bus.ss_wdat,
                         bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdat}, 0);
      // save with addr^5A mapper, 1-cycle ack
      clear(); op = 0;
      pulse(1'b1, 1'b0);
      wait_end(act_end);
      chk("t1_buf0", mbuf[0], 8'h5A);
      chk("t1_buf255", mbuf[255], 8'hA5);
      chk("t1_writes", nwr, 256);
      chk("t1_done", ndone, 1);
      chk("t1_busy_cyc", busy_cyc, 1024);
      chk("t1_busy_low", busy, 0);
      // load with matching index
      mode = 1; idx = 8'h33;
      for (int i = 0; i < 256; i++) begin mbuf[i] = 8'(i * 3 + 15); mreg[i] = 8'd0; end
      mbuf[127] = idx;
      clear(); op = 1;
      sync_m2();
      pulse(1'b0, 1'b1);
      wait_end(act_end);
      chk("t2_reg0", mreg[0], 8'h0F);
      chk("t2_we_pulses", nwe, 256);
      chk("t2_reads", nrd, 257);
      chk("t2_done", ndone, 1);
      bad = 0;
      for (int i = 0; i < 256; i++) if (mreg[i] !== mbuf[i]) bad++;
      chk("t2_regs", bad, 0);
      // load with index mismatch
      mbuf[127] = 8'h10; idx = 8'h11;
      clear(); op = 1;
      pulse(1'b0, 1'b1);
      wait_end(act_end);
      chk("t3_err", nerr, 1);
      chk("t3_done", ndone, 0);
      chk("t3_we", nwe, 0);
      chk("t3_act_on_err", act_end, 0);
      chk("t3_reads", nrd, 1);
      // load ignored during save, then simultaneous commands start a save
      mode = 0; clear(); op = 0;
      pulse(1'b1, 1'b0);
      repeat (100) @(posedge clk);
      pulse(1'b0, 1'b1);
      wait_end(act_end);
      chk("t4a_writes", nwr, 256);
      chk("t4a_done", ndone, 1);
      chk("t4a_we", nwe, 0);
      clear();
      pulse(1'b1, 1'b1);
      wait_end(act_end);
      chk("t4b_writes", nwr, 256);
      chk("t4b_we", nwe, 0);
      chk("t4b_buf10", mbuf[10], 8'h50);
      // reset while waiting for the m2 fall of byte 40
      mode = 1; idx = 8'h33;
      for (int i = 0; i < 256; i++) mbuf[i] = 8'(i + 1);
      mbuf[127] = idx;
      clear(); op = 1;
      sync_m2();
      pulse(1'b0, 1'b1);
      n = 0; mp = m2;
      do begin
         @(negedge clk);
         n++;
         if (bus.ss_we && bus.ss_addr == 8'd40 && m2 && !mp) break;
         mp = m2;
      end while (n < 5000);
      chk("t5_reach40", n < 5000, 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t5_outs", {busy, done, err, bus.ss_act, bus.ss_we, bus.ss_addr, bus.ss_wdat,
                      bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdat}, 0);
      chk("t5_partial", mreg[39], 8'd40);
      mode = 0; clear(); op = 0;
      pulse(1'b1, 1'b0);
      wait_end(act_end);
      chk("t5_writes", nwr, 256);
      chk("t5_done", ndone, 1);
      chk("t5_busy_cyc", busy_cyc, 1024);
      // round trip with random buffer latency
      mode = 1; idx = 8'h5C; lat_min = 1; lat_max = 7; one_fall = 0;
      for (int i = 0; i < 256; i++) begin
         mreg[i] = 8'($urandom_range(255, 0));
         gold[i] = (i == 127) ? idx : mreg[i];
      end
      clear(); op = 0;
      pulse(1'b1, 1'b0);
      wait_end(act_end);
      chk("t6_save_done", ndone, 1);
      for (int i = 0; i < 256; i++) mreg[i] = ~mreg[i];
      clear(); op = 1;
      sync_m2();
      pulse(1'b0, 1'b1);
      wait_end(act_end);
      chk("t6_load_done", ndone, 1);
      chk("t6_we_pulses", nwe, 256);
      bad = 0;
      for (int i = 0; i < 256; i++) if (mreg[i] !== gold[i]) bad++;
      chk("t6_roundtrip", bad, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
